req_encoder8to3: RTL and testbench
==================================

// Module: req_encoder8to3
// PURPOSE
//  Sequential 8-to-3 priority encoder; the encoding counterpart of the 3-to-8 active-low line decoder.
//  Captures falling edges on eight active-low request lines into a pending register.
//  Presents the winning index as a 3-bit code with a valid/ack handshake.
//  Provides 74148-style cascade flags (gs_n, eo_n) for building wider encoders.
// PARAMETERS
//  NREQ   8   number of request lines (fixed; code width 3)
//  CODEW  3   output code width
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous active-low reset
//  nreq     in   8  active-low request lines; a 1->0 transition raises a request
//  ei_n     in   1  active-low enable input; high blocks capture and cascade flags
//  ack      in   1  consumer accepts presented code (sampled only while valid=1)
//  code     out  3  index of the presented request
//  valid    out  1  code is valid; held until ack
//  pending  out  8  pending-request register (bit i = line i pending)
//  gs_n     out  1  group select: 0 when ei_n=0 and pending!=0
//  eo_n     out  1  enable out: 0 when ei_n=0 and pending==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, code=0, valid=0, pending=0, nreq_q=8'hFF, last=7.
//   Because gs_n/eo_n derive from registers and ei_n: after reset gs_n=1, eo_n=ei_n.
//  Edge capture: nreq_q <= nreq each clock. fall[i] = nreq_q[i] & ~nreq[i].
//   If ei_n=0: pending[i] is set on the same edge that fall[i] is seen.
//   If ei_n=1: falls are discarded (not deferred); nreq_q still updates.
//  FSM, two states:
//   IDLE: ack ignored. If pending!=0 and ei_n=0: code <= winner; valid <= 1; go PRESENT.
//   PRESENT: code/valid held stable. On ack=1: valid <= 0; pending[code] cleared; go IDLE.
//   ei_n rising during PRESENT does not abort; presentation continues until ack.
//  Latency: line low at sample edge k -> pending set at k -> valid=1 after edge k+1.
//  Throughput: valid low for at least 1 cycle between consecutive codes.
//  Simultaneous set/clear of the same pending bit (new fall on the ack cycle): set wins, bit stays 1.
//  Winner (fixed priority): highest set index of pending (7 highest, 0 lowest).
//  pending always shows the register; gs_n=~(~ei_n & |pending); eo_n=~(~ei_n & ~|pending).
//  Reset mid-PRESENT: valid drops immediately (async); all pending requests lost.
// CONFIGURATION
//  RR_PRIORITY_EN defined: rotating priority. On ack, last <= code.
//   The next search begins at index last-1 and proceeds downward, wrapping 0 -> 7.
//   The line just served is lowest priority.
//  RR_PRIORITY_EN undefined: fixed priority as above; 'last' register is not built.
// TESTING
//  T1: nreq=8'hDF (bit5 falls), ei_n=0 -> valid=1, code=5 two edges later; ack=1 one cycle -> valid=0, pending=0.
//  T2: bits 6 and 2 fall together -> code=6 first; after ack, valid=0 one cycle, then code=2; gs_n=0 until final ack, then eo_n=0.
//  T3: ei_n=1, bit3 falls, later ei_n=0 -> pending stays 0, valid never asserts; gs_n=1, eo_n=1 while ei_n=1.
//  T4: ack pulsed in IDLE -> no change. Bit6 re-falls on the cycle its code is acked -> pending[6]=1, code 6 re-presented.
//  T5: rst_n=0 while valid=1, code=4 -> valid=0, code=0, pending=0 without waiting for clk.
//  T6: bits 7 and 4 pending, 7 served, new fall on bit7 -> RR_PRIORITY_EN: code=4 next; without macro: code=7 next.

Source files
------------

// File: rtl/req_encoder8to3.sv
// req_encoder8to3: sequential 8-to-3 priority encoder with falling-edge request capture,
// valid/ack handshake and 74148-style cascade flags (gs_n, eo_n).
// Optional build macro RR_PRIORITY_EN selects rotating priority (line just served is lowest);
// without it the highest pending index always wins.
module req_encoder8to3 #(
    parameter int NREQ  = 8,
    parameter int CODEW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  nreq,
    input  logic             ei_n,
    input  logic             ack,
    output logic [CODEW-1:0] code,
    output logic             valid,
    output logic [NREQ-1:0]  pending,
    output logic             gs_n,
    output logic             eo_n
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           r_state;
    logic [CODEW-1:0] r_code;
    logic             r_valid;
    logic [NREQ-1:0]  r_pending;
    logic [NREQ-1:0]  r_nreq_q;
    logic [NREQ-1:0]  w_set;
    logic [NREQ-1:0]  w_clr;
    logic [CODEW-1:0] w_win;
    logic             w_done;

    // Falls are only captured while enabled; an ack in PRESENT retires the presented line.
    assign w_done = (r_state == PRESENT) && ack;
    assign w_set  = ei_n ? '0 : (r_nreq_q & ~nreq);
    assign w_clr  = w_done ? (NREQ'(1) << r_code) : '0;

`ifdef RR_PRIORITY_EN
    logic [CODEW-1:0] r_last;
    logic [CODEW-1:0] w_idx;

    // Remember the line just served so it becomes lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= CODEW'(NREQ - 1);
        else if (w_done)
            r_last <= r_code;
    end

    // Search downward from last-1 with wrap; iterating far-to-near lets the nearest hit win.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = r_last - CODEW'(k);
            if (r_pending[w_idx])
                w_win = w_idx;
        end
    end
`else
    // Fixed priority: highest set index wins.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NREQ; i++)
            if (r_pending[i])
                w_win = CODEW'(i);
    end
`endif

    // Edge capture, pending bookkeeping (set beats clear) and the IDLE/PRESENT handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_pending <= '0;
            r_nreq_q  <= '1;
        end else begin
            r_nreq_q  <= nreq;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (r_state == IDLE) begin
                if (|r_pending && !ei_n) begin
                    r_code  <= w_win;
                    r_valid <= 1'b1;
                    r_state <= PRESENT;
                end
            end else if (ack) begin
                r_valid <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign gs_n    = ~(~ei_n & |r_pending);
    assign eo_n    = ~(~ei_n & ~|r_pending);
endmodule

// File: tb/tb_req_encoder8to3.sv
// tb_req_encoder8to3: directed bench; expected codes are queued at stimulus time and a
// monitor checks each new presentation (rising valid) against the queue.
module tb_req_encoder8to3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] nreq;
    logic       ei_n;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       gs_n;
    logic       eo_n;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];

    req_encoder8to3 dut (
        .clk(clk), .rst_n(rst_n), .nreq(nreq), .ei_n(ei_n), .ack(ack),
        .code(code), .valid(valid), .pending(pending), .gs_n(gs_n), .eo_n(eo_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each new presentation must match the oldest queued expectation.
    initial begin
        logic pv;
        logic [2:0] e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !pv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_code: got %0d expected none", code);
                end else begin
                    e = exp_q.pop_front();
                    chk("code", 32'(code), 32'(e));
                end
            end
            pv = valid;
        end
    end

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got valid=0 expected valid=1", name);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        nreq  = 8'hFF;
        ei_n  = 1'b0;
        ack   = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_gs_n", 32'(gs_n), 1);
        chk("rst_eo_n_en", 32'(eo_n), 0);
        ei_n = 1'b1;
        #1;
        chk("rst_eo_n_dis", 32'(eo_n), 1);
        ei_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single request on line 5
        nreq = 8'hDF;
        exp_q.push_back(3'd5);
        @(negedge clk);
        chk("t1_pending", 32'(pending), 32'h20);
        chk("t1_not_yet_valid", 32'(valid), 0);
        chk("t1_gs_n", 32'(gs_n), 0);
        wait_valid("t1");
        ack_pulse();
        chk("t1_valid_after_ack", 32'(valid), 0);
        chk("t1_pending_after_ack", 32'(pending), 0);
        chk("t1_eo_n", 32'(eo_n), 0);
        nreq = 8'hFF;

        // T2: lines 6 and 2 together; 6 first, gap, then 2
        @(negedge clk);
        nreq = 8'hBB;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        wait_valid("t2a");
        ack_pulse();
        chk("t2_gap", 32'(valid), 0);
        chk("t2_pending_mid", 32'(pending), 32'h04);
        chk("t2_gs_n_mid", 32'(gs_n), 0);
        wait_valid("t2b");
        chk("t2_gs_n_last", 32'(gs_n), 0);
        ack_pulse();
        chk("t2_pending_end", 32'(pending), 0);
        chk("t2_eo_n_end", 32'(eo_n), 0);
        chk("t2_gs_n_end", 32'(gs_n), 1);
        nreq = 8'hFF;

        // T3: falls while disabled are discarded
        @(negedge clk);
        ei_n = 1'b1;
        nreq = 8'hF7;
        #1;
        chk("t3_gs_n", 32'(gs_n), 1);
        chk("t3_eo_n", 32'(eo_n), 1);
        repeat (3) @(negedge clk);
        chk("t3_pending_dis", 32'(pending), 0);
        ei_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_pending_en", 32'(pending), 0);
        chk("t3_valid", 32'(valid), 0);
        nreq = 8'hFF;

        // T4: ack in IDLE is ignored; re-fall on the ack cycle wins over the clear
        @(negedge clk);
        ack_pulse();
        chk("t4_idle_ack_valid", 32'(valid), 0);
        chk("t4_idle_ack_pending", 32'(pending), 0);
        nreq = 8'hBF;
        exp_q.push_back(3'd6);
        @(negedge clk);
        nreq = 8'hFF;
        wait_valid("t4a");
        nreq = 8'hBF;
        exp_q.push_back(3'd6);
        ack_pulse();
        chk("t4_set_wins", 32'(pending), 32'h40);
        chk("t4_gap", 32'(valid), 0);
        wait_valid("t4b");
        ack_pulse();
        nreq = 8'hFF;
        chk("t4_pending_end", 32'(pending), 0);

        // T6: serve line 2 first so 7 beats 4 in either priority mode
        @(negedge clk);
        nreq = 8'hFB;
        exp_q.push_back(3'd2);
        @(negedge clk);
        nreq = 8'hFF;
        wait_valid("t6a");
        ack_pulse();
        nreq = 8'h6F;
        exp_q.push_back(3'd7);
        @(negedge clk);
        nreq = 8'hEF;
        wait_valid("t6b");
        chk("t6_pending_both", 32'(pending), 32'h90);
        nreq = 8'h6F;
`ifdef RR_PRIORITY_EN
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd7);
`else
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
`endif
        ack_pulse();
        chk("t6_refall", 32'(pending), 32'h90);
        wait_valid("t6c");
        ack_pulse();
        wait_valid("t6d");
        ack_pulse();
        nreq = 8'hFF;
        chk("t6_pending_end", 32'(pending), 0);

        // T5: async reset while presenting code 4
        @(negedge clk);
        nreq = 8'hEF;
        exp_q.push_back(3'd4);
        wait_valid("t5");
        chk("t5_code_before", 32'(code), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(valid), 0);
        chk("t5_code", 32'(code), 0);
        chk("t5_pending", 32'(pending), 0);
        nreq = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_quiet_valid", 32'(valid), 0);
        chk("t5_queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
